// File: rtl/task2.sv
// rtl/task2.sv - ARC4 key-scheduling top: identity fill then in-place KSA on a 256x8 state RAM

// Innermost storage array; the read address is sampled on the clock, so q trails it by one cycle
module task2_ram_core (
    input  logic       clk,
    input  logic [7:0] address,
    input  logic [7:0] data,
    input  logic       wren,
    output logic [7:0] q
);
    logic [7:0] mem_data [0:255];

    // Write on enable; always read the addressed word into q (old data on a same-address write)
    always_ff @(posedge clk) begin
        if (wren) begin
            mem_data[address] <= data;
        end
        q <= mem_data[address];
    end
endmodule

// Wrapper layer so the array sits at the same hierarchical path as the vendor RAM model
module task2_ram_default (
    input  logic       clk,
    input  logic [7:0] address,
    input  logic [7:0] data,
    input  logic       wren,
    output logic [7:0] q
);
    task2_ram_core altsyncram_inst (
        .clk     (clk),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q)
    );
endmodule

// Wrapper layer standing in for the altsyncram component
module task2_ram_component (
    input  logic       clk,
    input  logic [7:0] address,
    input  logic [7:0] data,
    input  logic       wren,
    output logic [7:0] q
);
    task2_ram_default m_default (
        .clk     (clk),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q)
    );
endmodule

// Single-port 256x8 state memory
module task2_s_mem (
    input  logic       clock,
    input  logic [7:0] address,
    input  logic [7:0] data,
    input  logic       wren,
    output logic [7:0] q
);
    task2_ram_component altsyncram_component (
        .clk     (clock),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q)
    );
endmodule

module task2 (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);
    typedef enum logic [3:0] {
        ST_INIT,
        ST_RD_I,
        ST_WAIT_I,
        ST_CALC_J,
        ST_RD_J,
        ST_WAIT_J,
        ST_WR_J,
        ST_WR_I,
        ST_FIN,
        ST_DONE
    } state_t;

    logic        rst_n;
    state_t      state;
    logic [7:0]  i;
    logic [7:0]  j;
    logic [7:0]  si;
    logic [7:0]  sj;
    logic [1:0]  kidx;
    logic [23:0] key;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        wren;
    logic        done;
    logic [7:0]  q;
    logic [7:0]  kbyte;
    logic        unused_keys;

    assign rst_n       = KEY[3];
    assign unused_keys = &{1'b0, KEY[2:0]};

    assign HEX0 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX3 = 7'h7F;
    assign HEX4 = 7'h7F;
    assign HEX5 = 7'h7F;
    assign LEDR = {9'b0, done};

    task2_s_mem s (
        .clock   (CLOCK_50),
        .address (addr),
        .data    (wdata),
        .wren    (wren),
        .q       (q)
    );

    // Key byte for the current i mod 3; bytes are taken most-significant first
    always_comb begin
        kbyte = key[7:0];
        case (kidx)
            2'd0:    kbyte = key[23:16];
            2'd1:    kbyte = key[15:8];
            default: kbyte = key[7:0];
        endcase
    end

    // Sequencer: identity fill, then one read-read-write-write swap per i; all RAM controls registered
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            i     <= 8'd0;
            j     <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
            kidx  <= 2'd0;
            key   <= 24'd0;
            addr  <= 8'd0;
            wdata <= 8'd0;
            wren  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    // wren is still low only on the first cycle after reset: latch the key once
                    if (!wren) begin
                        key <= {14'd0, SW};
                    end
                    addr  <= i;
                    wdata <= i;
                    wren  <= 1'b1;
                    i     <= i + 8'd1;
                    if (i == 8'hFF) begin
                        state <= ST_RD_I;
                    end
                end
                ST_RD_I: begin
                    // The previous iteration's s[i] write lands on this same edge
                    addr  <= i;
                    wren  <= 1'b0;
                    state <= ST_WAIT_I;
                end
                ST_WAIT_I: begin
                    state <= ST_CALC_J;
                end
                ST_CALC_J: begin
                    si    <= q;
                    j     <= j + q + kbyte;
                    state <= ST_RD_J;
                end
                ST_RD_J: begin
                    addr  <= j;
                    state <= ST_WAIT_J;
                end
                ST_WAIT_J: begin
                    state <= ST_WR_J;
                end
                ST_WR_J: begin
                    sj    <= q;
                    addr  <= j;
                    wdata <= si;
                    wren  <= 1'b1;
                    state <= ST_WR_I;
                end
                ST_WR_I: begin
                    addr  <= i;
                    wdata <= sj;
                    wren  <= 1'b1;
                    i     <= i + 8'd1;
                    kidx  <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
                    state <= (i == 8'hFF) ? ST_FIN : ST_RD_I;
                end
                ST_FIN: begin
                    wren  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                default: begin
                    wren  <= 1'b0;
                    state <= ST_DONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_task2.sv
// tb/tb_task2.sv - self-checking bench for task2 against a software ARC4 KSA model
module tb_task2;
    logic       clk = 1'b0;
    logic [3:0] KEY = 4'hF;
    logic [9:0] SW  = 10'd0;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    int passed = 0;
    int total  = 0;
    int bad    = 0;
    int rises  = 0;
    int gold [256];

    task2 dut (
        .CLOCK_50 (clk),
        .KEY      (KEY),
        .SW       (SW),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .LEDR     (LEDR)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (HEX0 !== 7'h7F || HEX1 !== 7'h7F || HEX2 !== 7'h7F || HEX3 !== 7'h7F ||
            HEX4 !== 7'h7F || HEX5 !== 7'h7F || LEDR[9:1] !== 9'd0)
            bad++;
    end

    always @(posedge LEDR[0]) rises++;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic build_gold(input logic [9:0] sw);
        int st [256];
        int kb [3];
        int jj;
        int t;
        kb[0] = 0;
        kb[1] = int'(sw) / 256;
        kb[2] = int'(sw) % 256;
        for (int n = 0; n < 256; n++) st[n] = n;
        jj = 0;
        for (int n = 0; n < 256; n++) begin
            jj = (jj + st[n] + kb[n % 3]) % 256;
            t = st[n]; st[n] = st[jj]; st[jj] = t;
        end
        for (int n = 0; n < 256; n++) gold[n] = st[n];
    endtask

    task automatic check_image(input string tag, input logic [9:0] sw);
        int mism;
        build_gold(sw);
        mism = 0;
        for (int n = 0; n < 256; n++)
            if (int'(dut.s.altsyncram_component.m_default.altsyncram_inst.mem_data[n]) !== gold[n])
                mism++;
        check(tag, mism, 0);
    endtask

    task automatic check_perm(input string tag);
        logic [255:0] seen;
        int missing;
        seen = '0;
        for (int n = 0; n < 256; n++)
            seen[dut.s.altsyncram_component.m_default.altsyncram_inst.mem_data[n]] = 1'b1;
        missing = 0;
        for (int n = 0; n < 256; n++) if (!seen[n]) missing++;
        check(tag, missing, 0);
    endtask

    task automatic check_identity(input string tag);
        int mism;
        mism = 0;
        for (int n = 0; n < 256; n++)
            if (int'(dut.s.altsyncram_component.m_default.altsyncram_inst.mem_data[n]) !== n)
                mism++;
        check(tag, mism, 0);
    endtask

    // Assert reset for 'hold' cycles with the given switches, then release
    task automatic start_run(input logic [9:0] sw, input int hold);
        @(negedge clk);
        KEY = 4'h7;
        SW  = sw;
        #1;
        check("reset_clears_done", int'(LEDR[0]), 0);
        repeat (hold) @(negedge clk);
        KEY = 4'hF;
    endtask

    task automatic full_run(input string tag, input logic [9:0] sw);
        int r0;
        start_run(sw, 1);
        r0 = rises;
        repeat (3000) @(negedge clk);
        check({tag, "_done_by_3000"}, int'(LEDR[0]), 1);
        repeat (340) @(negedge clk);
        check_image({tag, "_image"}, sw);
        check({tag, "_one_rise"}, rises - r0, 1);
    endtask

    initial begin
        int r0;
        logic [9:0] rsw;

        // Power-on reset state
        KEY = 4'h7;
        repeat (3) @(negedge clk);
        check("reset_ledr", int'(LEDR), 0);
        check("reset_hex0", int'(HEX0), 7'h7F);

        // Key 00 03 3C with a probe right after the identity fill
        start_run(10'h33C, 1);
        r0 = rises;
        repeat (260) @(negedge clk);
        check_identity("init_identity");
        check("not_done_after_init", int'(LEDR[0]), 0);
        repeat (2740) @(negedge clk);
        check("k33c_done_by_3000", int'(LEDR[0]), 1);
        repeat (340) @(negedge clk);
        check_image("k33c_image", 10'h33C);
        check("k33c_one_rise", rises - r0, 1);

        // All-zero key
        full_run("k000", 10'h000);
        check_perm("k000_permutation");

        // Reset mid-KSA, held two cycles, then a full fresh run
        start_run(10'h33C, 1);
        repeat (1000) @(negedge clk);
        KEY = 4'h7;
        #1;
        check("midreset_done_low", int'(LEDR[0]), 0);
        repeat (2) @(negedge clk);
        KEY = 4'hF;
        r0 = rises;
        repeat (3340) @(negedge clk);
        check_image("midreset_image", 10'h33C);
        check("midreset_one_rise", rises - r0, 1);
        check("midreset_done", int'(LEDR[0]), 1);

        // Switch change during KSA is ignored
        start_run(10'h33C, 1);
        r0 = rises;
        repeat (600) @(negedge clk);
        SW = 10'h3FF;
        repeat (2740) @(negedge clk);
        check_image("swchange_image", 10'h33C);
        check("swchange_one_rise", rises - r0, 1);

        // Random keys
        for (int n = 0; n < 3; n++) begin
            rsw = 10'($urandom_range(0, 1023));
            full_run($sformatf("rand%0d_%03h", n, rsw), rsw);
            check_perm($sformatf("rand%0d_permutation", n));
        end

        check("static_outputs_violations", bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
